// File: rtl/aes_key_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : aes_key_scheduler                                          |
// | Description : Sequencer for a combinational single-round AES-128 key     |
// |               expansion unit. It loads a cipher key and steps the unit   |
// |               through rounds 1..NUM_ROUNDS, one round per cycle. Every   |
// |               round key goes into an (NUM_ROUNDS+1)-entry store. The     |
// |               store is then read by the cipher round datapath with a     |
// |               registered read.                                           |
// | Ports       : clk, rst_n        clock, async active-low reset            |
// |               start, key_in     expansion request / cipher key           |
// |               busy, done,       status: expanding, completion pulse,     |
// |               key_ready         all round keys valid                     |
// |               ke_key, ke_round  drive to the expansion unit              |
// |               ke_next           next round key from the expansion unit   |
// |               rd_en, rd_addr    round-key read request                   |
// |               rd_data, rd_valid registered read response                 |
// |               rd_err            read error flag (KEY_SCHED_ERR_EN only)  |
// | Options     : define KEY_SCHED_ERR_EN to add the rd_err output           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module aes_key_scheduler #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         key_ready,
  output logic [127:0] ke_key,
  output logic [3:0]   ke_round,
  input  logic [127:0] ke_next,
  input  logic         rd_en,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_data,
  output logic         rd_valid
`ifdef KEY_SCHED_ERR_EN
  ,
  output logic         rd_err
`endif
);

  localparam logic [3:0] c_LAST_ROUND = 4'(NUM_ROUNDS);
  localparam int         c_DEPTH      = NUM_ROUNDS + 1;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_EXPAND = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [3:0]   r_round;
  logic [127:0] r_work;
  logic [127:0] r_slot [c_DEPTH];
  logic         r_done;
  logic         r_key_ready;
  logic [127:0] r_rd_data;
  logic         r_rd_valid;
  logic         w_accept;
  logic         w_last;
  logic         w_addr_ok;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_EXPAND;
        end
      end
      S_EXPAND: begin
        if (r_round == c_LAST_ROUND) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------- round counter / work reg
  // The round counter returns to 0 on completion so it never moves past
  // the last round and ke_round reads 0 while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_round     <= 4'd0;
      r_work      <= '0;
      r_done      <= 1'b0;
      r_key_ready <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_work      <= key_in;
        r_round     <= 4'd1;
        r_key_ready <= 1'b0;
      end else if (r_state == S_EXPAND) begin
        r_work <= ke_next;
        if (w_last) begin
          r_round     <= 4'd0;
          r_key_ready <= 1'b1;
        end else begin
          r_round <= r_round + 4'd1;
        end
      end
    end
  end

  // ------------------------------------------------------- round-key store
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_slot[i] <= '0;
      end
    end else if (w_accept) begin
      r_slot[0] <= key_in;
    end else if (r_state == S_EXPAND) begin
      r_slot[r_round] <= ke_next;
    end
  end

  // ------------------------------------------------------------- read port
  // The read samples the store before this edge's write, so a read that
  // collides with a slot update returns the old contents.
  assign w_addr_ok = (rd_addr <= c_LAST_ROUND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_data <= w_addr_ok ? r_slot[rd_addr] : '0;
      end
    end
  end

`ifdef KEY_SCHED_ERR_EN
  logic r_rd_err;
  logic w_rd_err;

  // A slot is valid if it has been written for the current key. During
  // expansion, slots below the current round are valid. When idle, all
  // slots are valid only once key_ready is set.
  always_comb begin
    w_rd_err = !w_addr_ok
             || ((r_state == S_EXPAND) && (rd_addr >= r_round))
             || ((r_state == S_IDLE) && !r_key_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_err <= 1'b0;
    end else begin
      r_rd_err <= rd_en && w_rd_err;
    end
  end

  assign rd_err = r_rd_err;
`endif

  // --------------------------------------------------------------- outputs
  assign busy      = (r_state == S_EXPAND);
  assign done      = r_done;
  assign key_ready = r_key_ready;
  assign ke_key    = r_work;
  assign ke_round  = (r_state == S_EXPAND) ? r_round : 4'd0;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_aes_key_scheduler                                       |
// | Description : Self-checking bench for aes_key_scheduler. It includes a   |
// |               behavioural AES-128 single-round expansion unit that feeds |
// |               ke_next. Read responses are checked against a scoreboard   |
// |               of expected words.                                         |
// | Options     : define KEY_SCHED_ERR_EN to also check rd_err               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_aes_key_scheduler;

  localparam logic [127:0] c_K_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] c_R1_FIPS = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] c_R10_FIPS= 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] c_K_SEQ   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] c_R10_SEQ = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] c_K_ALT   = 128'hdeadbeef0badf00dcafef00d12345678;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         key_ready;
  logic [127:0] ke_key;
  logic [3:0]   ke_round;
  logic [127:0] ke_next;
  logic         rd_en;
  logic [3:0]   rd_addr;
  logic [127:0] rd_data;
  logic         rd_valid;
`ifdef KEY_SCHED_ERR_EN
  logic         rd_err;
`endif

  typedef struct {
    logic [127:0] data;
    logic         err;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_errors = 0;
  logic [127:0] rk_fips [11];
  logic [127:0] rk_seq  [11];

  always #5 clk = ~clk;

  aes_key_scheduler #(.NUM_ROUNDS(10)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .done      (done),
    .key_ready (key_ready),
    .ke_key    (ke_key),
    .ke_round  (ke_round),
    .ke_next   (ke_next),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid)
`ifdef KEY_SCHED_ERR_EN
    ,
    .rd_err    (rd_err)
`endif
  );

  // ---------------------------------------------- AES-128 reference model
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box computed from its definition: GF(2^8) inverse (x^254), then affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] s;
    logic [7:0] b;
    s = x; b = 8'h01;
    for (int i = 0; i < 7; i++) begin
      s = gmul(s, s);
      b = gmul(b, s);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [3:0] rnd);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rc;
    case (rnd)
      4'd1: rc = 8'h01;  4'd2: rc = 8'h02;  4'd3: rc = 8'h04;
      4'd4: rc = 8'h08;  4'd5: rc = 8'h10;  4'd6: rc = 8'h20;
      4'd7: rc = 8'h40;  4'd8: rc = 8'h80;  4'd9: rc = 8'h1b;
      4'd10: rc = 8'h36;
      default: rc = 8'h00;
    endcase
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
       ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign ke_next = next_key(ke_key, ke_round);

  // ------------------------------------------------------------- checking
  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (sb.size() == 0) begin
        check("rd_unexpected", 128'd1, 128'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rd_data", rd_data, e.data);
`ifdef KEY_SCHED_ERR_EN
        check("rd_err", {127'd0, rd_err}, {127'd0, e.err});
`endif
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [127:0] d, input logic err);
    exp_t e;
    e.data = d;
    e.err  = err;
    sb.push_back(e);
  endtask

  task automatic rd(input logic [3:0] a, input logic [127:0] d, input logic err);
    rd_en   = 1'b1;
    rd_addr = a;
    push(d, err);
    tick;
    rd_en = 1'b0;
    check("rd_valid", {127'd0, rd_valid}, 128'd1);
  endtask

  // Drives start with key and runs until done. It can inject a second start
  // at loop sample inj_at and issue one read at loop sample rd_at. It
  // returns in the cycle done is high.
  task automatic run_expand(input logic [127:0] key, input int inj_at,
                            input logic [127:0] inj_key, input int rd_at,
                            input logic [3:0] rd_a, input logic [127:0] rd_d,
                            input logic rd_e);
    int n;
    int bc;
    start  = 1'b1;
    key_in = key;
    tick;
    start = 1'b0;
    check("accept_key_ready", {127'd0, key_ready}, 128'd0);
    check("accept_busy", {127'd0, busy}, 128'd1);
    check("accept_ke_key", ke_key, key);
    n  = 0;
    bc = 0;
    while (!done && n < 20) begin
      if (busy) bc++;
      if (n == 2) check("ke_round", {124'd0, ke_round}, 128'd3);
      start = (n == inj_at);
      if (n == inj_at) key_in = inj_key;
      rd_en = (n == rd_at);
      if (n == rd_at) begin
        rd_addr = rd_a;
        push(rd_d, rd_e);
      end
      tick;
      n++;
    end
    start = 1'b0;
    rd_en = 1'b0;
    check("latency", 128'(n + 1), 128'd11);
    check("busy_cycles", 128'(bc), 128'd10);
    check("done_key_ready", {127'd0, key_ready}, 128'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int j;
    int k;
    int done_j;
    rst_n = 1'b0; start = 1'b0; key_in = '0; rd_en = 1'b0; rd_addr = '0;

    rk_fips[0] = c_K_FIPS;
    rk_seq[0]  = c_K_SEQ;
    for (int i = 1; i < 11; i++) begin
      rk_fips[i] = next_key(rk_fips[i-1], 4'(i));
      rk_seq[i]  = next_key(rk_seq[i-1], 4'(i));
    end

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_done", {127'd0, done}, 128'd0);
    check("rst_key_ready", {127'd0, key_ready}, 128'd0);
    check("rst_rd_valid", {127'd0, rd_valid}, 128'd0);
    check("rst_ke_round", {124'd0, ke_round}, 128'd0);
    check("rst_ke_key", ke_key, 128'd0);
    check("rst_rd_data", rd_data, 128'd0);

    // FIPS-197 key: latency, done width and known round keys.
    run_expand(c_K_FIPS, -1, '0, -1, 4'd0, '0, 1'b0);
    tick;
    check("done_width", {127'd0, done}, 128'd0);
    check("ready_hold", {127'd0, key_ready}, 128'd1);
    rd(4'd1, c_R1_FIPS, 1'b0);
    rd(4'd10, c_R10_FIPS, 1'b0);
    rd(4'd0, c_K_FIPS, 1'b0);
    rd(4'd12, 128'd0, 1'b1);

    // A second start while busy is ignored.
    run_expand(c_K_FIPS, 4, c_K_ALT, -1, 4'd0, '0, 1'b0);
    tick;
    for (int a = 0; a < 11; a++) rd(4'(a), rk_fips[a], 1'b0);

    // Reset at cycle 4 of an expansion.
    start  = 1'b1;
    key_in = c_K_SEQ;
    tick;
    start = 1'b0;
    repeat (3) tick;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {127'd0, busy}, 128'd0);
    check("mid_rst_done", {127'd0, done}, 128'd0);
    check("mid_rst_key_ready", {127'd0, key_ready}, 128'd0);
    check("mid_rst_rd_valid", {127'd0, rd_valid}, 128'd0);
    check("mid_rst_ke_round", {124'd0, ke_round}, 128'd0);
    check("mid_rst_ke_key", ke_key, 128'd0);
    check("mid_rst_rd_data", rd_data, 128'd0);
    tick;
    rst_n = 1'b1;
    rd(4'd3, 128'd0, 1'b1);
    // Read slot 7 at cycle 3 of expansion: it still holds the cleared value.
    run_expand(c_K_FIPS, -1, '0, 2, 4'd7, 128'd0, 1'b1);
    tick;
    rd(4'd10, c_R10_FIPS, 1'b0);
    rd(4'd4, rk_fips[4], 1'b0);

    // Back-to-back start accepted in the done cycle.
    run_expand(c_K_FIPS, -1, '0, -1, 4'd0, '0, 1'b0);
    run_expand(c_K_SEQ, -1, '0, -1, 4'd0, '0, 1'b0);
    tick;
    rd(4'd10, c_R10_SEQ, 1'b0);
    rd(4'd5, rk_seq[5], 1'b0);

    // Continuous reads, descending addresses, during a restart. A read
    // sampled j edges after the accepting edge sees the new slot k if j > k.
    done_j = -1;
    start  = 1'b1;
    key_in = c_K_FIPS;
    for (j = 0; j < 22; j++) begin
      if (done && done_j < 0) done_j = j;
      k       = 10 - (j % 11);
      rd_en   = 1'b1;
      rd_addr = 4'(k);
      push((j > k) ? rk_fips[k] : rk_seq[k], (j >= 1 && j <= 10 && k >= j));
      tick;
      start = 1'b0;
    end
    rd_en = 1'b0;
    check("sweep_done_at", 128'(done_j), 128'd11);
    tick;
    tick;
    check("sb_drained", 128'(sb.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
